sipo_deserializer: RTL and testbench

Receive-side counterpart of the 10-bit PISO serializer: accepts the LSB-first serial stream and rebuilds 10-bit parallel words. Word boundaries are recovered by comma (K28.5) alignment, in both running-disparity forms. Output is a registered word plus a one-cycle valid strobe, ready for the downstream 8b/10b decoder.

---
 rtl/serdes_pkg.sv | 7 +
 rtl/comma_detect.sv | 12 +
 rtl/sipo_deserializer.sv | 88 ++++++++
 tb/tb_sipo_deserializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared word width, K28.5 comma values and aligner state type
package serdes_pkg;
    localparam int WORD_W = 10;
    localparam logic [WORD_W-1:0] K28_5_NEG = 10'h17C;
    localparam logic [WORD_W-1:0] K28_5_POS = 10'h283;
    typedef enum logic {HUNT, LOCK} align_state_t;
endpackage

// File: rtl/comma_detect.sv
// comma_detect: flags a 10-bit window equal to either K28.5 disparity form
module comma_detect
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] COMMA_NEG = K28_5_NEG,
    parameter logic [WORD_W-1:0] COMMA_POS = K28_5_POS
) (
    input  logic [WORD_W-1:0] win,
    output logic              match
);
    assign match = (win == COMMA_NEG) || (win == COMMA_POS);
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial to 10-bit words with K28.5 comma alignment
module sipo_deserializer
    import serdes_pkg::*;
#(
    parameter int                LOSS_THRESH = 4,
    parameter logic [WORD_W-1:0] COMMA_NEG   = K28_5_NEG,
    parameter logic [WORD_W-1:0] COMMA_POS   = K28_5_POS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic [WORD_W-1:0] par_out,
    output logic              par_valid,
    output logic              is_comma,
    output logic              locked
);
    logic [WORD_W-1:0] sr, win;
    logic [3:0]        bit_cnt, bit_d, miss_cnt, miss_d;
    logic              match, emit;
    align_state_t      state, state_d;

    assign win = {ser_in, sr[WORD_W-1:1]};

    comma_detect #(.COMMA_NEG(COMMA_NEG), .COMMA_POS(COMMA_POS)) u_comma (
        .win  (win),
        .match(match)
    );

    // Aligner: lock on first comma, emit every 10th bit, realign after LOSS_THRESH stray commas
    always_comb begin
        state_d = state;
        bit_d   = bit_cnt;
        miss_d  = miss_cnt;
        emit    = 1'b0;
        if (ser_valid) begin
            if (state == HUNT) begin
                if (match) begin
                    emit    = 1'b1;
                    bit_d   = 4'd0;
                    miss_d  = 4'd0;
                    state_d = LOCK;
                end
            end else if (bit_cnt == 4'd9) begin
                emit   = 1'b1;
                bit_d  = 4'd0;
                miss_d = match ? 4'd0 : miss_cnt;
            end else if (match && (miss_cnt + 4'd1 == 4'(LOSS_THRESH))) begin
                emit   = 1'b1;
                bit_d  = 4'd0;
                miss_d = 4'd0;
            end else begin
                bit_d  = bit_cnt + 4'd1;
                miss_d = match ? miss_cnt + 4'd1 : miss_cnt;
            end
        end
    end

    // State, counters and shift register; all hold while ser_valid is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            bit_cnt  <= 4'd0;
            miss_cnt <= 4'd0;
            sr       <= '0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_d;
            miss_cnt <= miss_d;
            if (ser_valid) sr <= win;
        end
    end

    // Registered word, strobe, comma flag and lock indication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            is_comma  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (emit) par_out <= win;
            par_valid <= emit;
            is_comma  <= emit & match;
            locked    <= (state_d == LOCK);
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed + swept stimulus with a queued scoreboard
module tb_sipo_deserializer;
    logic       clk = 1'b0, rst = 1'b0, ser_in = 1'b0, ser_valid = 1'b0;
    logic [9:0] par_out;
    logic       par_valid, is_comma, locked;
    int         cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [9:0] w;
        logic       c;
        int         t;
    } exp_t;
    exp_t q[$];
    exp_t e;

    sipo_deserializer dut (
        .clk      (clk),
        .rst      (rst),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .par_out  (par_out),
        .par_valid(par_valid),
        .is_comma (is_comma),
        .locked   (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic send(input logic b, input logic v);
        @(posedge clk);
        #1;
        ser_in    = b;
        ser_valid = v;
    endtask

    task automatic expect_word(input logic [9:0] w, input int t);
        exp_t x;
        x.w = w;
        x.c = (w == 10'h17C) || (w == 10'h283);
        x.t = t;
        q.push_back(x);
    endtask

    task automatic send_word(input logic [9:0] w, input bit emit);
        for (int i = 0; i < 10; i++) send(w[i], 1'b1);
        if (emit) expect_word(w, cyc + 1);
    endtask

    function automatic bit bad(input logic [9:0] a, input logic [9:0] b);
        logic [19:0] s;
        s = {b, a};
        for (int k = 1; k < 10; k++)
            if (s[k+:10] == 10'h17C || s[k+:10] == 10'h283) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every strobe must match the oldest queued expectation, including its cycle
    always @(negedge clk) begin
        if (par_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_strobe: got par_out=%h expected no strobe", par_out);
            end else begin
                e = q.pop_front();
                chk("word", par_out, e.w);
                chk("is_comma", is_comma, e.c);
                chk("strobe_cycle", cyc, e.t);
            end
        end else if (is_comma) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_is_comma: got 1 expected 0");
        end
    end

    initial begin
        int          r, c0;
        logic [42:0] s;
        logic [9:0]  w, prev, wd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_par_out", par_out, 0);
        chk("rst_par_valid", par_valid, 0);
        chk("rst_is_comma", is_comma, 0);
        chk("rst_locked", locked, 0);

        // Lock from HUNT: 3 filler bits then RD- comma, strobe on 13th sampled bit
        @(posedge clk);
        #1 rst = 1'b1;
        r = cyc;
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        send_word(10'h17C, 1'b0);
        expect_word(10'h17C, r + 14);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("locked_after_lock", locked, 1);

        // Steady data, back-to-back
        send_word(10'h283, 1'b1);
        send_word(10'h2A5, 1'b1);

        // Gapped word: 5 idle cycles after 4th bit
        w = 10'h155;
        send(w[0], 1'b1);
        c0 = cyc;
        for (int i = 1; i < 4; i++) send(w[i], 1'b1);
        repeat (5) send(1'b1, 1'b0);
        for (int i = 4; i < 10; i++) send(w[i], 1'b1);
        expect_word(10'h155, c0 + 15);

        // Realign: 3-bit slip then four commas; garbage words then the 4th comma
        s = {{4{10'h17C}}, 3'b010};
        for (int i = 0; i < 43; i++) begin
            send(s[i], 1'b1);
            if (i % 10 == 9) expect_word(10'h3E2, cyc + 1);
            if (i == 42) expect_word(10'h17C, cyc + 1);
        end
        send_word(10'h283, 1'b1);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("locked_after_realign", locked, 1);

        // Mid-word asynchronous reset
        w = 10'h2A5;
        for (int i = 0; i < 6; i++) send(w[i], 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        ser_valid = 1'b0;
        #1;
        chk("mid_rst_par_out", par_out, 0);
        chk("mid_rst_par_valid", par_valid, 0);
        chk("mid_rst_is_comma", is_comma, 0);
        chk("mid_rst_locked", locked, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        send_word(10'h2A5, 1'b0);
        send_word(10'h2A5, 1'b0);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("hunt_after_rst", locked, 0);
        send_word(10'h17C, 1'b1);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("relock_after_rst", locked, 1);

        // Sweep: 1000 words, comma every 16th, no stray comma across boundaries
        prev = 10'h17C;
        for (int n = 0; n < 1000; n++) begin
            if (n % 16 == 0) begin
                w = ((n / 16) % 2 == 1) ? 10'h283 : 10'h17C;
            end else begin
                wd = ((n + 1) % 16 == 0) ? ((((n + 1) / 16) % 2 == 1) ? 10'h283 : 10'h17C) : 10'h000;
                do w = 10'($urandom_range(0, 1023));
                while (bad(prev, w) || ((n + 1) % 16 == 0 && bad(w, wd)));
            end
            send_word(w, 1'b1);
            prev = w;
        end
        repeat (12) send(1'b0, 1'b0);
        @(negedge clk);
        chk("pending_words", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
